rect_fill_ctrl: RTL and testbench
=================================

Name: rect_fill_ctrl

Overview:
- Upstream drawing engine for the SDRAM/VGA graphic sub-module. It fills an axis-aligned rectangle of the frame buffer with one 16-bit colour.
- Accepts one fill command from the host core. It converts the command into a row-major sequence of single-word SDRAM write calls on the graphic sub-module's write channel.
- Frame-buffer addressing is fixed: address = {5'd0, Y[9:0], X[8:0]}, i.e. 512 words per line, 1024 lines.

Parameters:
- XMAX, 9'd511, last valid X column; the fill is clipped to this.
- YMAX, 10'd1023, last valid Y line; the fill is clipped to this.

Ports:
- iClock  in  1  main clock (the 100 MHz core clock domain of the graphic sub-module).
- RESET  in  1  asynchronous, active-low reset.
- iCall  in  1  fill request; held high by the host until oDone.
- oDone  out  1  one-cycle pulse when the fill completes.
- oBusy  out  1  high from command acceptance until the oDone cycle, inclusive.
- iX  in  9  start column.
- iY  in  10  start line.
- iW  in  9  width minus one.
- iH  in  10  height minus one.
- iColor  in  16  fill colour.
- oCall  out  2  to graphic sub-module: [1] write, [0] read; [0] is always 0.
- iDone  in  2  from graphic sub-module: [1] write done, [0] read done; [0] is ignored.
- oAddr  out  24  SDRAM word address.
- oData  out  16  SDRAM write data.
- oCount  out  20  words written by the current or last fill.

Behaviour:
- Clocking and reset:
  - Single clock iClock; all state updates on its rising edge.
  - RESET low is asynchronous and active-low. It forces state IDLE and clears oCall, oDone, oBusy, oAddr, oData, oCount and all internal registers to 0.
  - Reset asserted mid-fill aborts the fill immediately; the write in flight is abandoned and no oDone is issued.
- States: IDLE, LOAD, WRITE, NEXT, FINISH, GAP.
- IDLE:
  - If iCall=1, latch iX, iY, iColor and compute the clipped end coordinates:
    - xe = min(iX+iW, XMAX), computed at 10 bits;
    - ye = min(iY+iH, YMAX), computed at 11 bits.
  - Set cx=iX, cy=iY, oCount=0, oBusy=1; go to LOAD.
- LOAD: oAddr <= {5'd0, cy, cx}; oData <= colour; go to WRITE.
- WRITE:
  - oCall = 2'b10 is held stable, together with oAddr and oData, until iDone[1] is sampled high.
  - On that cycle: oCall <= 0, oCount <= oCount+1, go to NEXT.
- NEXT:
  - oCall stays 0 for at least this cycle; this is required because the sub-module's core drops its call on done.
  - If cx != xe: cx <= cx+1, go to LOAD.
  - Else if cy != ye: cx <= x0, cy <= cy+1, go to LOAD.
  - Else go to FINISH.
- FINISH: oDone = 1 for exactly one cycle, oBusy remains 1 during it; go to GAP.
- GAP: oBusy = 0 and iCall is ignored for one cycle, so a host dropping iCall on oDone does not re-trigger; go to IDLE.
- Latency:
  - Per word: 2 cycles + sub-module write latency L (cycles from oCall[1] rising to iDone[1]).
  - Whole fill: 1 + N*(L+2) + 2 cycles, where N = (xe-x0+1)*(ye-y0+1).
- Input and handshake rules:
  - Command inputs are sampled only in IDLE; changes during a fill are ignored.
  - iCall dropped mid-fill does not abort the fill.
  - iDone[1] outside WRITE is ignored. iDone[0] is always ignored.
  - oCall[0] is constantly 0; oCall[1] never overlaps a read call from this block.
- Boundaries:
  - iW=0 and iH=0 gives a single word.
  - If iX+iW overflows past XMAX, the row is clipped at XMAX; likewise lines are clipped at YMAX. There is no wrap-around.
  - Start at XMAX/YMAX gives one word at address {5'd0, 10'd1023, 9'd511} = 24'h07FFFF.
  - oCount is held after completion until the next command is accepted.

Test Plan:
- Reset values: apply reset → all outputs 0. Release reset with iCall=0 → oCall stays 0 for 20 cycles.
- Single word: iX=5, iY=3, iW=0, iH=0, iColor=16'hF800, model with L=3 → one write, oAddr=24'h00_0605, oData=F800. Then oDone pulses once, oCount=1, total 1+5+2=8 cycles.
- 3x2 fill: iX=10, iY=20, iW=2, iH=1 → six writes at addresses 0x280A, 0x280B, 0x280C, 0x2A0A, 0x2A0B, 0x2A0C in that order. oCall must be low for at least 1 cycle between writes; oCount=6.
- Clipping: iX=510, iY=1022, iW=4, iH=4 → exactly 4 writes: (510,1022), (511,1022), (510,1023), (511,1023). There must be no address with X<510.
- Handshake stress: randomize L from 1 to 10 and hold iCall high for 3 cycles past oDone → oAddr/oData stable throughout each WRITE, no second fill starts, and a spurious iDone[1] pulse in NEXT or IDLE has no effect.
- Reset mid-fill: assert RESET during the 4th WRITE of a 4x4 fill → oCall=0 immediately. After release the block is in IDLE; a new 1x1 fill then completes normally with oCount=1.

Source files
------------

// File: rtl/rect_fill_ctrl_if.sv
// Command and SDRAM write-channel bundle for rect_fill_ctrl.
// slave is the fill engine's view; master is the host / graphic sub-module view.
interface rect_fill_ctrl_if;
    logic        iCall;
    logic        oDone;
    logic        oBusy;
    logic [8:0]  iX;
    logic [9:0]  iY;
    logic [8:0]  iW;
    logic [9:0]  iH;
    logic [15:0] iColor;
    logic [1:0]  oCall;
    logic [1:0]  iDone;
    logic [23:0] oAddr;
    logic [15:0] oData;
    logic [19:0] oCount;

    modport slave (
        input  iCall, iX, iY, iW, iH, iColor, iDone,
        output oDone, oBusy, oCall, oAddr, oData, oCount
    );

    modport master (
        output iCall, iX, iY, iW, iH, iColor, iDone,
        input  oDone, oBusy, oCall, oAddr, oData, oCount
    );
endinterface

// File: rtl/rect_fill_ctrl.sv
// Rectangle fill engine: turns one fill command into a row-major stream of
// single-word SDRAM write calls, clipped to the frame-buffer edges.
module rect_fill_ctrl #(
    parameter logic [8:0] XMAX = 9'd511,
    parameter logic [9:0] YMAX = 10'd1023
) (
    input logic            iClock,
    input logic            RESET,
    rect_fill_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_NEXT,
        S_FINISH,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  x0_q, x0_d;
    logic [8:0]  cx_q, cx_d;
    logic [8:0]  xe_q, xe_d;
    logic [9:0]  cy_q, cy_d;
    logic [9:0]  ye_q, ye_d;
    logic [15:0] color_q, color_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [19:0] count_q, count_d;

    logic [9:0]  xsum;
    logic [10:0] ysum;

    // End coordinates computed one bit wider so overflow past the edge clips
    // instead of wrapping.
    assign xsum = {1'b0, bus.iX} + {1'b0, bus.iW};
    assign ysum = {1'b0, bus.iY} + {1'b0, bus.iH};

    always_ff @(posedge iClock or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            cx_q    <= '0;
            xe_q    <= '0;
            cy_q    <= '0;
            ye_q    <= '0;
            color_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            cx_q    <= cx_d;
            xe_q    <= xe_d;
            cy_q    <= cy_d;
            ye_q    <= ye_d;
            color_q <= color_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        cx_d    = cx_q;
        xe_d    = xe_q;
        cy_d    = cy_q;
        ye_d    = ye_q;
        color_d = color_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (bus.iCall) begin
                    x0_d    = bus.iX;
                    cx_d    = bus.iX;
                    cy_d    = bus.iY;
                    color_d = bus.iColor;
                    xe_d    = (xsum > {1'b0, XMAX}) ? XMAX : xsum[8:0];
                    ye_d    = (ysum > {1'b0, YMAX}) ? YMAX : ysum[9:0];
                    count_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                addr_d  = {5'd0, cy_q, cx_q};
                data_d  = color_q;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.iDone[1]) begin
                    count_d = count_q + 20'd1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // One idle call cycle between words lets the sub-module's
                // core observe its call drop before the next request.
                if (cx_q != xe_q) begin
                    cx_d    = cx_q + 9'd1;
                    state_d = S_LOAD;
                end else if (cy_q != ye_q) begin
                    cx_d    = x0_q;
                    cy_d    = cy_q + 10'd1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_GAP;
            S_GAP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Call, done and busy decode straight from state so a reset drops them
    // in the same instant as the state register.
    assign bus.oCall  = {state_q == S_WRITE, 1'b0};
    assign bus.oDone  = (state_q == S_FINISH);
    assign bus.oBusy  = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                        (state_q == S_NEXT) || (state_q == S_FINISH);
    assign bus.oAddr  = addr_q;
    assign bus.oData  = data_q;
    assign bus.oCount = count_q;

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Bench for rect_fill_ctrl: a write-channel responder with configurable latency
// checks every write against a queue of expected {address, colour} words.
module tb_rect_fill_ctrl;

    logic iClock = 1'b0;
    logic RESET;

    rect_fill_ctrl_if bus();

    rect_fill_ctrl #(.XMAX(9'd511), .YMAX(10'd1023)) dut (
        .iClock (iClock),
        .RESET  (RESET),
        .bus    (bus.slave)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        int          x;
        int          y;
        int          w;
        int          h;
        logic [15:0] color;
        int          lat;      // 0 selects a random latency 1..10 per word
        int          exp_n;
        logic [23:0] exp_a0;
    } vec_t;

    vec_t        vecs [7];
    logic [39:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          writes_seen = 0;
    int          lat_sum = 0;
    int          fixed_lat = 1;
    bit          rand_lat = 1'b0;
    bit          spurious = 1'b0;
    logic [23:0] first_addr = '0;

    always @(posedge iClock) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Write-channel responder: raises iDone[1] L cycles after oCall[1] rises.
    initial begin : responder
        int          wcnt;
        int          cur_l;
        logic [23:0] a;
        logic [15:0] d;
        logic [39:0] e;
        wcnt  = 0;
        cur_l = 1;
        a     = '0;
        d     = '0;
        bus.iDone = 2'b00;
        forever begin
            @(negedge iClock);
            if (bus.oCall[1]) begin
                if (wcnt == 0) begin
                    a = bus.oAddr;
                    d = bus.oData;
                    writes_seen++;
                    if (writes_seen == 1) first_addr = a;
                    cur_l = rand_lat ? int'($urandom_range(1, 10)) : fixed_lat;
                    lat_sum += cur_l;
                    check("ocall_read_bit", 64'(bus.oCall[0]), 64'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=%0h expected=none", a);
                    end else begin
                        e = sb.pop_front();
                        check("write_addr", 64'(a), 64'(e[39:16]));
                        check("write_data", 64'(d), 64'(e[15:0]));
                    end
                end else begin
                    check("write_hold_stable", 64'({bus.oAddr, bus.oData}), 64'({a, d}));
                end
                wcnt++;
                bus.iDone[1] = (wcnt == cur_l);
            end else begin
                wcnt = 0;
                bus.iDone[1] = spurious && ($urandom_range(0, 3) == 0);
            end
            bus.iDone[0] = 1'($urandom_range(0, 1));
        end
    end

    task automatic push_model(input vec_t v, output int n);
        int xe;
        int ye;
        xe = (v.x + v.w > 511) ? 511 : v.x + v.w;
        ye = (v.y + v.h > 1023) ? 1023 : v.y + v.h;
        n  = 0;
        for (int yy = v.y; yy <= ye; yy++) begin
            for (int xx = v.x; xx <= xe; xx++) begin
                sb.push_back({yy * 512 + xx, v.color});
                n++;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int c0;
        bit got;
        sb.delete();
        push_model(v, n);
        writes_seen = 0;
        lat_sum     = 0;
        rand_lat    = (v.lat == 0);
        spurious    = (v.lat == 0);
        fixed_lat   = v.lat;
        @(negedge iClock);
        bus.iX     = 9'(v.x);
        bus.iY     = 10'(v.y);
        bus.iW     = 9'(v.w);
        bus.iH     = 10'(v.h);
        bus.iColor = v.color;
        bus.iCall  = 1'b1;
        c0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge iClock);
            if (k == 0) begin
                bus.iX     = 9'($urandom);
                bus.iY     = 10'($urandom);
                bus.iW     = 9'($urandom);
                bus.iH     = 10'($urandom);
                bus.iColor = 16'($urandom);
            end
            if (bus.oDone) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_oDone expected=oDone");
        end else begin
            check("fill_cycles", 64'(cyc - c0), 64'(2 * n + lat_sum + 1));
            check("busy_at_done", 64'(bus.oBusy), 64'd1);
            check("ocount", 64'(bus.oCount), 64'(v.exp_n));
            check("writes_seen", 64'(writes_seen), 64'(v.exp_n));
            check("first_addr", 64'(first_addr), 64'(v.exp_a0));
            check("queue_empty", 64'(sb.size()), 64'd0);
        end
        @(negedge iClock);
        check("done_one_cycle", 64'({bus.oDone, bus.oBusy}), 64'd0);
        bus.iCall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge iClock);
            check("no_refill", 64'({bus.oBusy, bus.oCall}), 64'd0);
        end
        check("ocount_held", 64'(bus.oCount), 64'(v.exp_n));
    endtask

    initial begin : main
        vec_t v;
        bit   got;
        int   n;
        vecs[0] = '{5,   3,    0,  0, 16'hF800, 3, 1,  24'h000605};
        vecs[1] = '{10,  20,   2,  1, 16'h07E0, 2, 6,  24'h00280A};
        vecs[2] = '{510, 1022, 4,  4, 16'h001F, 1, 4,  24'h07FDFE};
        vecs[3] = '{511, 1023, 0,  0, 16'hFFFF, 4, 1,  24'h07FFFF};
        vecs[4] = '{0,   0,    3,  2, 16'h1234, 0, 12, 24'h000000};
        vecs[5] = '{500, 7,    20, 0, 16'hABCD, 0, 12, 24'h000FF4};
        vecs[6] = '{100, 1020, 1,  9, 16'h5A5A, 0, 8,  24'h07F864};

        RESET      = 1'b0;
        bus.iCall  = 1'b0;
        bus.iX     = '0;
        bus.iY     = '0;
        bus.iW     = '0;
        bus.iH     = '0;
        bus.iColor = '0;
        #12;
        check("reset_outputs",
              64'({bus.oCall, bus.oDone, bus.oBusy, bus.oAddr, bus.oData, bus.oCount}), 64'd0);
        @(negedge iClock);
        RESET = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge iClock);
            check("idle_no_call", 64'({bus.oCall, bus.oBusy}), 64'd0);
        end

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset during the fourth write of a 4x4 fill.
        v = '{8, 8, 3, 3, 16'hC0DE, 3, 16, 24'h001008};
        sb.delete();
        push_model(v, n);
        writes_seen = 0;
        rand_lat    = 1'b0;
        spurious    = 1'b0;
        fixed_lat   = 3;
        @(negedge iClock);
        bus.iX     = 9'(v.x);
        bus.iY     = 10'(v.y);
        bus.iW     = 9'(v.w);
        bus.iH     = 10'(v.h);
        bus.iColor = v.color;
        bus.iCall  = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge iClock);
            if (writes_seen == 4) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL reset_fill_timeout actual=%0d expected=4", writes_seen);
        end
        check("in_write_before_reset", 64'(bus.oCall), 64'd2);
        RESET = 1'b0;
        #1;
        check("reset_midfill",
              64'({bus.oCall, bus.oDone, bus.oBusy, bus.oAddr, bus.oData, bus.oCount}), 64'd0);
        bus.iCall = 1'b0;
        @(negedge iClock);
        sb.delete();
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge iClock);
            check("idle_after_reset", 64'({bus.oBusy, bus.oCall, bus.oDone}), 64'd0);
        end
        run_vec('{3, 4, 0, 0, 16'h0F0F, 2, 1, 24'h000803});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
